// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI initiator for the SPI slave / single-port RAM subsystem.
//
// A parallel request {req_cmd, req_data} is serialized as a 10-bit frame,
// MSB first, on MOSI while SS_n is low. For read-data (cmd=11) the bus is
// turned around for READ_WAIT cycles and an 8-bit reply is shifted in from
// MISO. Out-of-order requests are rejected locally with a one-cycle err.
//
// Ports:
//   clk        system clock, also the SPI bit clock seen by the slave
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  controller can accept a request (high only in IDLE)
//   req_cmd    00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   req_data   payload byte
//   rsp_valid  one-cycle pulse, rsp_data valid
//   rsp_data   byte read from RAM, held until the next response
//   err        one-cycle pulse on a rejected, out-of-order request
//   busy       high whenever the controller is not IDLE
//   SS_n       slave select, active low
//   MOSI       serial data to slave, MSB first
//   MISO       serial data from slave, MSB first
module spi_master_ctrl #(
  parameter int unsigned READ_WAIT = 2,  // turnaround cycles, 1..15
  parameter int unsigned IDLE_GAP  = 1   // SS_n-high cycles after a frame, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd1;
  localparam logic [2:0] ST_TURN      = 3'd2;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [3:0] TURN_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  logic [2:0] state;
  logic [9:0] tx_shreg;      // outgoing frame, bit 9 is on MOSI
  logic [1:0] frame_cmd;     // command of the frame in flight
  logic [3:0] cnt;           // per-state cycle counter
  logic [7:0] rx_shreg;      // incoming reply, assembled MSB first
  logic       wr_addr_seen;  // a write address has completed since reset
  logic       rd_pending;    // a read address awaits its read-data frame
  logic       req_illegal;

  // Outputs decoded straight from state so the async reset forces SS_n high
  // and MOSI low in the same instant, without waiting for a clock edge.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign SS_n      = !((state == ST_SHIFT_OUT) || (state == ST_TURN) ||
                       (state == ST_SHIFT_IN));
  assign MOSI      = (state == ST_SHIFT_OUT) ? tx_shreg[9] : 1'b0;

  assign req_illegal = ((req_cmd == CMD_WR_DATA) && !wr_addr_seen) ||
                       ((req_cmd == CMD_RD_DATA) && !rd_pending);

  // NOTE: every register here, datapath included, is reset; the block holds
  // no memory array, so a full reset costs nothing and keeps outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx_shreg     <= '0;
      frame_cmd    <= CMD_WR_ADDR;
      cnt          <= '0;
      rx_shreg     <= '0;
      wr_addr_seen <= 1'b0;
      rd_pending   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      err          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the
      // defaults below make err and rsp_valid single-cycle pulses.
      err       <= 1'b0;
      rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              err <= 1'b1;
            end else begin
              tx_shreg  <= {req_cmd, req_data};
              frame_cmd <= req_cmd;
              cnt       <= '0;
              state     <= ST_SHIFT_OUT;
            end
          end
        end

        ST_SHIFT_OUT: begin
          tx_shreg <= {tx_shreg[8:0], 1'b0};
          if (cnt == 4'd9) begin
            cnt <= '0;
            if (frame_cmd == CMD_RD_DATA) begin
              state <= ST_TURN;
            end else begin
              // Flags change only once the frame has fully gone out.
              state <= ST_GAP;
              if (frame_cmd == CMD_WR_ADDR) wr_addr_seen <= 1'b1;
              if (frame_cmd == CMD_RD_ADDR) rd_pending   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= ST_SHIFT_IN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_SHIFT_IN: begin
          rx_shreg <= {rx_shreg[6:0], MISO};
          if (cnt == 4'd7) begin
            // The 8th sample goes straight to rsp_data alongside the pulse.
            rsp_data   <= {rx_shreg[6:0], MISO};
            rsp_valid  <= 1'b1;
            rd_pending <= 1'b0;
            cnt        <= '0;
            state      <= ST_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
